// File: rtl/projeto_pkg.sv
// Shared definitions for the byte-serial operand front end of projetoFinal.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: loader FSM state encoding, frame length, byte slot indices and
// operand widths used by the interface, the assembler and the loader.
package projeto_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ARM    = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  // Bytes per operand frame: A(2) B(2) C(2) K(1).
  localparam int FRAME_BYTES = 7;

  localparam int BYTE_W = 8;
  localparam int OPND_W = 16;
  localparam int K_W    = 8;

  // Position of each byte within a frame, big-endian per operand.
  localparam logic [2:0] IDX_A_HI = 3'd0;
  localparam logic [2:0] IDX_A_LO = 3'd1;
  localparam logic [2:0] IDX_B_HI = 3'd2;
  localparam logic [2:0] IDX_B_LO = 3'd3;
  localparam logic [2:0] IDX_C_HI = 3'd4;
  localparam logic [2:0] IDX_C_LO = 3'd5;
  localparam logic [2:0] IDX_K    = 3'd6;
  localparam logic [2:0] IDX_LAST = 3'(FRAME_BYTES - 1);

  // Byte index after `idx`, wrapping to 0 after the last byte of a frame.
  function automatic logic [2:0] idx_next(input logic [2:0] idx);
    return (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Bundle of the loader's host byte port, result port and projetoFinal link.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on bytes, out_valid/out_ready on results.
//
// master: the loader side (drives in_ready, operands, inicio, results, err).
// slave : the environment side (host plus projetoFinal).
interface operand_loader_if;
  import projeto_pkg::*;

  // Host byte stream.
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;

  // Operands and start/done handshake towards projetoFinal.
  logic [OPND_W-1:0] a;
  logic [OPND_W-1:0] b;
  logic [OPND_W-1:0] c;
  logic [K_W-1:0]    k;
  logic              inicio;
  logic              pronto;
  logic [OPND_W-1:0] resultado;

  // Host result word.
  logic              out_valid;
  logic [OPND_W-1:0] out_data;
  logic              out_ready;

  // Timeout abort pulse.
  logic              err;

  modport master (
    input  in_valid, in_data, pronto, resultado, out_ready,
    output in_ready, a, b, c, k, inicio, out_valid, out_data, err
  );

  modport slave (
    output in_valid, in_data, pronto, resultado, out_ready,
    input  in_ready, a, b, c, k, inicio, out_valid, out_data, err
  );

endinterface

// File: rtl/frame_assembler.sv
// Collects 7 bytes into the A/B/C/K operand registers and flags frame end.
// Latency: operand slot updated on the edge that accepts its byte.
// Backpressure: none of its own; byte_vld must already include the ready.
//
// Ports: clk, rst (async active-low); byte_vld/byte_dat accepted byte;
//        a, b, c, k registered operands; frame_done same-cycle strobe
//        asserted while the last byte of a frame is being accepted.
module frame_assembler
  import projeto_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_dat,
  output logic [OPND_W-1:0] a,
  output logic [OPND_W-1:0] b,
  output logic [OPND_W-1:0] c,
  output logic [K_W-1:0]    k,
  output logic              frame_done
);

  logic [2:0]        idx_q, idx_d;
  logic [OPND_W-1:0] a_q, a_d;
  logic [OPND_W-1:0] b_q, b_d;
  logic [OPND_W-1:0] c_q, c_d;
  logic [K_W-1:0]    k_q, k_d;

  always_comb begin
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    k_d        = k_q;
    frame_done = 1'b0;
    if (byte_vld) begin
      case (idx_q)
        IDX_A_HI: a_d[15:8] = byte_dat;
        IDX_A_LO: a_d[7:0]  = byte_dat;
        IDX_B_HI: b_d[15:8] = byte_dat;
        IDX_B_LO: b_d[7:0]  = byte_dat;
        IDX_C_HI: c_d[15:8] = byte_dat;
        IDX_C_LO: c_d[7:0]  = byte_dat;
        IDX_K:    k_d       = byte_dat;
        default:  ;
      endcase
      frame_done = (idx_q == IDX_LAST);
      idx_d      = idx_next(idx_q);
    end
  end

  // Reset drops any partially received frame: the index restarts at byte 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      k_q   <= '0;
    end else begin
      idx_q <= idx_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      k_q   <= k_d;
    end
  end

  assign a = a_q;
  assign b = b_q;
  assign c = c_q;
  assign k = k_q;

endmodule

// File: rtl/operand_loader.sv
// Byte-serial operand loader: frame in, start projetoFinal, result word out.
// Latency: last byte at edge n -> inicio high from edge n+1 (if pronto low).
// Backpressure: in_ready only in LOAD; result held until out_ready.
//
// Ports: clk, rst (async active-low); bus (operand_loader_if.master):
//   in_valid/in_data/in_ready  host byte stream
//   a/b/c/k/inicio             operands and start level to projetoFinal
//   pronto/resultado           done and result from projetoFinal
//   out_valid/out_data/out_ready  result word to host
//   err                        one-cycle pulse on timeout abort
// Every output comes straight from a flop.
module operand_loader
  import projeto_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000  // 1..65535 RUN cycles before abort
) (
  input  logic             clk,
  input  logic             rst,
  operand_loader_if.master bus
);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              inicio_q, inicio_d;
  logic              out_valid_q, out_valid_d;
  logic [OPND_W-1:0] out_data_q, out_data_d;
  logic              err_q, err_d;

  logic              byte_acc;
  logic              frame_done;
  logic              cnt_expire;

  assign byte_acc = bus.in_valid && in_ready_q;

  frame_assembler u_frame_assembler (
    .clk        (clk),
    .rst        (rst),
    .byte_vld   (byte_acc),
    .byte_dat   (bus.in_data),
    .a          (bus.a),
    .b          (bus.b),
    .c          (bus.c),
    .k          (bus.k),
    .frame_done (frame_done)
  );

  // The counter reaches TIMEOUT on this edge; compared one bit wider so
  // TIMEOUT = 65535 cannot alias through a wrap.
  assign cnt_expire = (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    err_d      = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (frame_done) state_d = ST_ARM;
      end

      // Hold off until pronto from the previous operation has dropped, so a
      // stale done is never mistaken for this frame's result.
      ST_ARM: begin
        if (!bus.pronto) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      // pronto is ignored in the first RUN cycle (cnt_q == 0) because
      // projetoFinal has not yet seen inicio high. A result arriving on the
      // same edge the timeout would fire wins over the abort.
      ST_RUN: begin
        cnt_d = cnt_q + 16'd1;
        if ((cnt_q != 16'd0) && bus.pronto) begin
          out_data_d = bus.resultado;
          state_d    = ST_RESULT;
        end else if (cnt_expire) begin
          err_d   = 1'b1;
          state_d = ST_LOAD;
        end
      end

      ST_RESULT: begin
        if (out_valid_q && bus.out_ready) state_d = ST_LOAD;
      end

      default: state_d = ST_LOAD;
    endcase

    // Level outputs are registered copies of the next state, so they change
    // on the same edge as the state itself.
    in_ready_d  = (state_d == ST_LOAD);
    inicio_d    = (state_d == ST_RUN);
    out_valid_d = (state_d == ST_RESULT);
  end

  // in_ready resets low even though the state is LOAD; it rises on the first
  // edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      inicio_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      inicio_q    <= inicio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.inicio    = inicio_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader with a behavioural projetoFinal stub.
// Stub: returns A+B+C+K a few cycles after inicio rises, holds pronto until
// inicio falls; can be told never to answer or to force pronto high.
module tb_operand_loader;

  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_loader_if bus ();

  operand_loader #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- projetoFinal stub ----------------
  logic        stub_never = 1'b0;
  logic        stub_hold  = 1'b0;
  logic        stub_p     = 1'b0;
  logic [15:0] stub_res   = 16'h0;
  int          stub_cnt   = 0;

  always @(negedge clk) begin
    if (!bus.inicio) begin
      stub_cnt = 0;
      stub_p   = 1'b0;
    end else if (!stub_never) begin
      stub_cnt++;
      if (stub_cnt == 5) begin
        stub_p   = 1'b1;
        stub_res = bus.a + bus.b + bus.c + {8'h00, bus.k};
      end
    end
  end

  assign bus.pronto    = stub_hold | stub_p;
  assign bus.resultado = stub_res;

  // ---------------- scoreboard monitor ----------------
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.out_valid && !ov_prev) begin
      if (exp_q.size() == 0) chk("spurious_result", 32'(bus.out_valid), 32'd0);
      else                   chk("result", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end
    ov_prev = bus.out_valid;
  end

  // ---------------- stimulus helpers (called just after a negedge) --------
  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr[7], input int gap, input bit push);
    logic [15:0] s;
    s = {fr[0], fr[1]} + {fr[2], fr[3]} + {fr[4], fr[5]} + {8'h00, fr[6]};
    if (push) exp_q.push_back(s);
    for (int i = 0; i < 7; i++) begin
      send_byte(fr[i]);
      if (gap != 0 && i < 6 && (i % 2) == 0) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic chk_ops(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] ec, input logic [7:0] ek);
    chk({tag, "_a"}, 32'(bus.a), 32'(ea));
    chk({tag, "_b"}, 32'(bus.b), 32'(eb));
    chk({tag, "_c"}, 32'(bus.c), 32'(ec));
    chk({tag, "_k"}, 32'(bus.k), 32'(ek));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int hi, ec, ov, n;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_inicio",    32'(bus.inicio),    32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk_ops("rst", 16'h0, 16'h0, 16'h0, 8'h0);
    rst = 1'b1;
    chk("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

    // 1: back-to-back frame.
    send_frame('{8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h06, 8'h08}, 0, 1'b1);
    chk_ops("t1", 16'd3, 16'd4, 16'd6, 8'd8);
    chk("t1_arm_inicio",   32'(bus.inicio),   32'd0);
    chk("t1_arm_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("t1_run_inicio", 32'(bus.inicio), 32'd1);
    wait_out("t1_out_valid");
    chk("t1_res_inicio", 32'(bus.inicio), 32'd0);
    @(negedge clk);
    chk("t1_done_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_done_in_ready",  32'(bus.in_ready),  32'd1);

    // 2: gapped frame, result held 10 cycles with out_ready low.
    bus.out_ready = 1'b0;
    send_frame('{8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h06, 8'h08}, 2, 1'b1);
    wait_out("t2_out_valid");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (10) begin
      @(negedge clk);
      chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_hold_data",  32'(bus.out_data),  32'h15);
      chk("t2_hold_rdy",   32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t2_rel_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t2_rel_in_ready",  32'(bus.in_ready),  32'd1);
    chk("t2_no_byte_taken", 32'(bus.a),         32'd3);

    // 3: stub never answers -> timeout.
    stub_never = 1'b1;
    send_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 0, 1'b0);
    hi = 0; ec = 0; ov = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.inicio) hi++;
      if (bus.out_valid) ov++;
      if (bus.err) begin
        ec++;
        chk("t3_err_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t3_err_inicio",   32'(bus.inicio),   32'd0);
      end
    end
    chk("t3_inicio_cycles", 32'(hi), 32'(TMO));
    chk("t3_err_cycles",    32'(ec), 32'd1);
    chk("t3_out_valid_cnt", 32'(ov), 32'd0);
    stub_never = 1'b0;

    // 4: stale pronto held high at frame completion.
    stub_hold = 1'b1;
    send_frame('{8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h40}, 0, 1'b1);
    repeat (6) begin
      @(negedge clk);
      chk("t4_arm_inicio",   32'(bus.inicio),   32'd0);
      chk("t4_arm_in_ready", 32'(bus.in_ready), 32'd0);
    end
    stub_hold = 1'b0;
    @(negedge clk);
    chk("t4_run_inicio", 32'(bus.inicio), 32'd1);
    wait_out("t4_out_valid");
    @(negedge clk);

    // 5: reset after 4 bytes, then again mid-RUN.
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    rst = 1'b0;
    #1;
    chk("t5a_a",        32'(bus.a),        32'd0);
    chk("t5a_b",        32'(bus.b),        32'd0);
    chk("t5a_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_frame('{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h01, 8'h02, 8'h03}, 0, 1'b0);
    chk_ops("t5b", 16'h0A0B, 16'h0C0D, 16'h0102, 8'h03);
    n = 0;
    while (!bus.inicio && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_inicio_up", 32'(bus.inicio), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5c_inicio",    32'(bus.inicio),    32'd0);
    chk("t5c_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5c_err",       32'(bus.err),       32'd0);
    chk_ops("t5c", 16'h0, 16'h0, 16'h0, 8'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_frame('{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h01, 8'h02, 8'h03}, 0, 1'b1);
    chk_ops("t5d", 16'h0A0B, 16'h0C0D, 16'h0102, 8'h03);
    wait_out("t5_out_valid");
    @(negedge clk);

    // 6: two frames back to back, first wraps to 0.
    send_frame('{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00}, 0, 1'b1);
    send_frame('{8'h12, 8'h34, 8'h00, 8'h10, 8'h01, 8'h00, 8'h05}, 0, 1'b1);
    chk_ops("t6", 16'h1234, 16'h0010, 16'h0100, 8'h05);
    wait_out("t6_out_valid");
    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Byte-serial front end for the `projetoFinal` datapath. It assembles a 7-byte operand frame into A, B, C (16 bit) and K (8 bit), drives `inicio` until `pronto` answers, then captures `resultado` and returns it through a valid/ready output port. It sits directly upstream of `projetoFinal` and also consumes its result, so a host only ever sees byte-in / word-out handshakes.

## Interface
- `TIMEOUT`, 1000: max cycles in RUN without `pronto` before abort; legal range 1..65535.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  operand byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `a`, `b`, `c`  out  16  operands to `projetoFinal`.
- `k`  out  8  operand to `projetoFinal`.
- `inicio`  out  1  start level to `projetoFinal`.
- `pronto`  in  1  done from `projetoFinal`.
- `resultado`  in  16  result from `projetoFinal`.
- `out_valid`  out  1  `out_data` holds a result.
- `out_data`  out  16  captured result.
- `out_ready`  in  1  host accepts result.
- `err`  out  1  one-cycle pulse on timeout abort.

## Operation
- Frame byte order: A[15:8], A[7:0], B[15:8], B[7:0], C[15:8], C[7:0], K. Byte accepted when `in_valid && in_ready`; 3-bit index 0..6.
- States: LOAD, ARM, RUN, RESULT.
- LOAD: `in_ready`=1. Each accepted byte is written into its operand slot and the index increments. The 7th byte goes to ARM and the index clears.
- ARM: `in_ready`=0, `inicio`=0. Waits until `pronto`==0, then goes to RUN. This guarantees a stale `pronto` from the previous operation is never taken as the new result.
- RUN: `inicio`=1 and the timeout counter increments each cycle. `pronto`==1 on any RUN cycle after the first: `resultado` goes into `out_data` and the state goes to RESULT. If the counter reaches `TIMEOUT` first: `err` pulses, the state returns to LOAD, and no result is produced.
- RESULT: `inicio`=0, `out_valid`=1. `out_data` is stable until `out_valid && out_ready`, then the state returns to LOAD.
- `a`, `b`, `c`, `k` hold their last written values from LOAD until overwritten by the next frame. They are stable throughout ARM and RUN.
- Reset mid-operation: everything returns to reset values immediately and any partial frame is discarded.

## Timing
- Reset values: `in_ready`=0, `inicio`=0, `out_valid`=0, `err`=0, `a`=`b`=`c`=0, `k`=0, `out_data`=0. The state is LOAD, but `in_ready` goes high only on the first clock edge after reset is released.
- Byte throughput: 1 byte per cycle in LOAD. 7 consecutive valid cycles complete a frame.
- Last byte accepted at edge n: ARM at n, RUN at n+1 at the earliest (when `pronto` is low), so `inicio` rises in the cycle after edge n+1.
- `pronto` sampled high at edge m (in RUN): `out_valid`=1 and `inicio`=0 from edge m.
- Result accepted at edge r: `out_valid`=0 and `in_ready`=1 from edge r.
- Timeout: `err` is high for exactly the one cycle after the edge at which the counter equals `TIMEOUT`. The counter clears on entry to RUN.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `projeto_pkg` holds:
  - the state encoding enum (LOAD, ARM, RUN, RESULT);
  - the `FRAME_BYTES`=7 constant;
  - the byte-index localparams.
- One natural sub-module, `frame_assembler`: the byte counter plus the operand slot registers, with a frame-complete strobe.
- The FSM and timeout counter live in `operand_loader`.

## Test plan
The bench uses a behavioural `projetoFinal` stub that returns A+B+C+K five cycles after `inicio` rises and holds `pronto` until `inicio` falls.

1. Reset then frame 00 03 00 04 00 06 08 on back-to-back cycles -> `a`=3, `b`=4, `c`=6, `k`=8; `inicio` high; then `out_valid` with `out_data`=0x0015; `inicio` low.
2. Same frame sent with `in_valid` gaps, and `out_ready` held low 10 cycles -> `out_data` stays 0x0015 and no byte is accepted until `out_ready`; then LOAD resumes.
3. Stub never asserts `pronto`, with `TIMEOUT`=20 -> `inicio` high for 20 cycles, then a one-cycle `err` pulse, `out_valid` never asserted, and `in_ready` returns.
4. Stub holds `pronto` high at frame completion -> loader stays in ARM with `inicio`=0 until `pronto` falls, then RUN.
5. `rst` asserted after 4 bytes and again mid-RUN -> all outputs return to 0 asynchronously. The next full frame is decoded from byte 0 correctly.
6. Two frames back-to-back (FF FF 00 01 00 00 00) -> `out_data`=0x0000, showing 16-bit wrap of the stub sum; a second frame yields the correct independent result.
